// File: rtl/pixel_fetch.sv
// pixel_fetch
// Upstream feeder of the VGA timing stage. It walks a linear frame buffer,
// issues in-order word reads to the memory arbiter and writes each returned
// pixel into the pixel FIFO one cycle after it arrives. It runs ahead of the
// raster and only as far as FIFO credit allows, so the FIFO never overflows.
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   enable          level, 1 = fetch frames continuously
//   fb_base         frame buffer base word address, sampled at frame start
//   mem_req/addr    read request and its word address (held until mem_gnt)
//   mem_gnt         request accepted this cycle
//   mem_rvalid/data in-order read return
//   fifo_wr/din     registered write into the pixel FIFO
//   fifo_level      current FIFO occupancy
//   frame_done      pulse together with the write of a frame's last pixel
//   busy            fetcher is not idle
//   err             sticky: a return arrived with nothing outstanding
module pixel_fetch #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_OUTST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [ADDR_W-1:0]             fb_base,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          fifo_wr,
    output logic [DATA_W-1:0]             fifo_din,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          err
);

    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = LW + 2;
    localparam logic [18:0] LAST_IDX = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [18:0]         r_pix_idx;
    logic [18:0]         r_ret_cnt;
    logic [OW-1:0]       r_outst;
    logic [ADDR_W-1:0]   r_base_q;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_fifo_wr;
    logic [DATA_W-1:0]   r_fifo_din;
    logic                r_frame_done;
    logic                r_busy;
    logic                r_err;

    logic                w_grant;
    logic                w_valid_ret;
    logic [OW-1:0]       w_outst_nxt;
    logic [CW-1:0]       w_credit_sum;
    logic                w_credit_ok;
    logic                w_issue;
    logic                w_start;
    logic                w_clear;
    logic [18:0]         w_pix_nxt;
    logic [ADDR_W-1:0]   w_base_nxt;

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign fifo_wr    = r_fifo_wr;
    assign fifo_din   = r_fifo_din;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign err        = r_err;

    assign w_grant     = r_mem_req & mem_gnt;
    // A return with nothing outstanding is an arbiter fault: it is dropped.
    assign w_valid_ret = mem_rvalid & (r_outst != '0);
    assign w_outst_nxt = r_outst + OW'(w_grant) - OW'(w_valid_ret);

    // Credit is judged on every pixel already committed after this edge:
    // FIFO contents, the write in flight, the return being registered now and
    // all reads outstanding (including a grant this cycle). A request raised
    // next cycle therefore always has a FIFO slot reserved for its data.
    assign w_credit_sum = CW'(fifo_level) + CW'(r_fifo_wr) + CW'(w_valid_ret)
                        + CW'(w_outst_nxt);
    assign w_credit_ok  = (w_outst_nxt < OW'(MAX_OUTST))
                        && (w_credit_sum < CW'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control strobes. A request already on the bus must be
    // granted before FETCH may either raise another one or leave for DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_start     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_FETCH;
                    w_start     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!r_mem_req || mem_gnt) begin
                    if (enable) begin
                        w_issue = w_credit_ok;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((r_outst == '0) && !r_fifo_wr) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pixel index and frame base after this edge. The base is resampled only
    // when a frame starts, so a mid-frame fb_base change applies next frame.
    always_comb begin
        w_pix_nxt  = r_pix_idx;
        w_base_nxt = r_base_q;
        if (w_start) begin
            w_pix_nxt  = '0;
            w_base_nxt = fb_base;
        end else if (w_grant) begin
            if (r_pix_idx == LAST_IDX) begin
                w_pix_nxt  = '0;
                w_base_nxt = fb_base;
            end else begin
                w_pix_nxt = r_pix_idx + 19'd1;
            end
        end else if (w_clear) begin
            w_pix_nxt = '0;
        end
    end

    // Request side: index, base, outstanding count and the request itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_idx  <= '0;
            r_base_q   <= '0;
            r_outst    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_pix_idx <= w_pix_nxt;
            r_base_q  <= w_base_nxt;
            r_outst   <= w_outst_nxt;
            r_mem_req <= w_issue | (r_mem_req & ~mem_gnt);
            if (w_issue) begin
                r_mem_addr <= w_base_nxt + ADDR_W'(w_pix_nxt);
            end
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    // Return side: registered FIFO write, frame counting and the error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_wr    <= 1'b0;
            r_fifo_din   <= '0;
            r_frame_done <= 1'b0;
            r_ret_cnt    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_fifo_wr    <= w_valid_ret;
            r_frame_done <= w_valid_ret && (r_ret_cnt == LAST_IDX);
            if (w_valid_ret) begin
                r_fifo_din <= mem_rdata;
            end
            if (w_clear) begin
                r_ret_cnt <= '0;
            end else if (w_valid_ret) begin
                r_ret_cnt <= (r_ret_cnt == LAST_IDX) ? 19'd0 : r_ret_cnt + 19'd1;
            end
            if (mem_rvalid && (r_outst == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_fetch.sv
// Testbench for pixel_fetch with a small 8x4 frame so full frames fit in a
// short run. A per-cycle model plays arbiter, memory and pixel FIFO; granted
// reads are pushed to a return queue and returned data to an expected-write
// queue that is popped when the DUT writes the FIFO.
module tb_pixel_fetch;

    localparam int H      = 8;
    localparam int V      = 4;
    localparam int TOTAL  = H * V;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, enable, mem_req, mem_gnt, mem_rvalid;
    logic              fifo_wr, frame_done, busy, err;
    logic [ADDR_W-1:0] fb_base, mem_addr;
    logic [DATA_W-1:0] mem_rdata, fifo_din;
    logic [4:0]        fifo_level;

    pixel_fetch #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(16), .MAX_OUTST(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fb_base(fb_base),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_level(fifo_level),
        .frame_done(frame_done), .busy(busy), .err(err)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } item_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int lat = 2;
    bit gnt_en = 1'b1;
    bit drain = 1'b1;
    bit inject = 1'b0;
    bit no_req = 1'b0;
    int lvl = 0;
    bit prev_wr = 1'b0;
    int max_lvl = 0;
    int grants = 0;
    int writes = 0;
    int wr_cnt = 0;
    int fd_pulses = 0;
    int last_wr_cyc = 0;
    bit busy_at_last_wr = 1'b0;
    logic [ADDR_W-1:0] mdl_base = '0;
    int mdl_idx = 0;

    item_t             ret_q[$];
    item_t             exp_q[$];
    logic [ADDR_W-1:0] gaddr_q[$];

    // One cycle of arbiter/memory/FIFO model, run at a falling edge after the
    // test code has set its inputs; then advances to the next falling edge.
    task automatic tick();
        item_t             it;
        logic [ADDR_W-1:0] ea;
        bit                efd;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            it = exp_q.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing_write cyc=%0d got none required din=%h", cyc, it.data);
        end
        if (fifo_wr) begin
            writes++;
            wr_cnt++;
            last_wr_cyc = cyc;
            busy_at_last_wr = busy;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write cyc=%0d got din=%h required no write", cyc, fifo_din);
            end else begin
                it = exp_q.pop_front();
                if (fifo_din !== it.data || cyc != it.due) begin
                    failures++;
                    $display("[TB] FAIL fifo_write got din=%h cyc=%0d required din=%h cyc=%0d",
                             fifo_din, cyc, it.data, it.due);
                end
            end
        end
        if (fifo_wr || frame_done) begin
            efd = fifo_wr && (wr_cnt % TOTAL == 0);
            checks++;
            if (frame_done !== efd) begin
                failures++;
                $display("[TB] FAIL frame_done cyc=%0d got %b required %b", cyc, frame_done, efd);
            end
        end
        if (frame_done) fd_pulses++;
        if (no_req) begin
            checks++;
            if (mem_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drain_no_req cyc=%0d got mem_req=%b required 0", cyc, mem_req);
            end
        end
        lvl += int'(prev_wr);
        prev_wr = fifo_wr;
        if (drain && lvl > 0) lvl--;
        if (lvl > max_lvl) max_lvl = lvl;
        fifo_level = 5'(lvl);
        mem_gnt = gnt_en;
        if (mem_req && mem_gnt) begin
            grants++;
            gaddr_q.push_back(mem_addr);
            ea = mdl_base + ADDR_W'(mdl_idx);
            checks++;
            if (mem_addr !== ea) begin
                failures++;
                $display("[TB] FAIL grant_addr got %h required %h", mem_addr, ea);
            end
            mdl_idx++;
            if (mdl_idx == TOTAL) begin
                mdl_idx = 0;
                mdl_base = fb_base;
            end
            it.due  = cyc + lat;
            it.data = {4'h9, mem_addr} ^ 24'h35A5A5;
            ret_q.push_back(it);
        end
        mem_rvalid = 1'b0;
        if (inject) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 24'hDEAD01;
            inject     = 1'b0;
        end else if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            it = ret_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = it.data;
            it.due     = cyc + 1;
            exp_q.push_back(it);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        fifo_level = '0;
        ret_q.delete();
        exp_q.delete();
        gaddr_q.delete();
        lat = 2; gnt_en = 1'b1; drain = 1'b1; inject = 1'b0; no_req = 1'b0;
        lvl = 0; prev_wr = 1'b0; max_lvl = 0;
        grants = 0; writes = 0; wr_cnt = 0; fd_pulses = 0; mdl_idx = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_fetch(input logic [ADDR_W-1:0] base);
        fb_base  = base;
        mdl_base = base;
        mdl_idx  = 0;
        enable   = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, fifo_wr, fifo_din, frame_done, busy, err} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got req=%b addr=%h wr=%b din=%h fd=%b busy=%b err=%b required all 0",
                     mem_req, mem_addr, fifo_wr, fifo_din, frame_done, busy, err);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_quiet got busy=%b req=%b required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        do_reset();
        start_fetch(20'h10000);
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_fetch_cycle got req=%b busy=%b required 0 1", mem_req, busy);
        end
        repeat (19) tick();
        w0 = writes;
        repeat (30) tick();
        checks++;
        if (writes - w0 != 30) begin
            failures++;
            $display("[TB] FAIL throughput got %0d writes required 30", writes - w0);
        end
        checks++;
        if (gaddr_q.size() < 2 || gaddr_q[0] !== 20'h10000 || gaddr_q[1] !== 20'h10001) begin
            failures++;
            $display("[TB] FAIL first_addrs got %0d grants required 0x10000,0x10001 first", gaddr_q.size());
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, fifo_wr, fifo_din, frame_done, busy, err} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset got req=%b addr=%h wr=%b busy=%b required all 0",
                     mem_req, mem_addr, fifo_wr, busy);
        end
    endtask

    task automatic test_credit();
        do_reset();
        drain = 1'b0;
        start_fetch(20'h10000);
        repeat (80) tick();
        checks++;
        if (grants != 16) begin
            failures++;
            $display("[TB] FAIL credit_grants got %0d required 16", grants);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL credit_req_drop got %b required 0", mem_req);
        end
        checks++;
        if (max_lvl != 16 || writes != 16) begin
            failures++;
            $display("[TB] FAIL credit_level got max=%0d writes=%0d required 16 16", max_lvl, writes);
        end
    endtask

    task automatic test_gnt_stall();
        logic [ADDR_W-1:0] a0;
        do_reset();
        gnt_en = 1'b0;
        start_fetch(20'h10000);
        for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
        a0 = mem_addr;
        checks++;
        if (mem_req !== 1'b1 || a0 !== 20'h10000) begin
            failures++;
            $display("[TB] FAIL stall_first_req got req=%b addr=%h required 1 10000", mem_req, a0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 20'h10000) begin
                failures++;
                $display("[TB] FAIL stall_hold got req=%b addr=%h required 1 10000", mem_req, mem_addr);
            end
        end
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        repeat (5) tick();
        checks++;
        if (grants != 1 || writes != 1) begin
            failures++;
            $display("[TB] FAIL stall_single_grant got grants=%0d writes=%0d required 1 1", grants, writes);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'h10001) begin
            failures++;
            $display("[TB] FAIL stall_next_addr got req=%b addr=%h required 1 10001", mem_req, mem_addr);
        end
    endtask

    task automatic test_frame();
        do_reset();
        start_fetch(20'h10000);
        for (int i = 0; i < 200 && writes < 70; i++) begin
            if (grants >= 10) fb_base = 20'h20000;
            tick();
        end
        checks++;
        if (writes < 70 || gaddr_q.size() < 65) begin
            failures++;
            $display("[TB] FAIL frame_timeout got writes=%0d grants=%0d required 70 65", writes, gaddr_q.size());
        end else begin
            checks++;
            if (gaddr_q[31] !== 20'h1001F || gaddr_q[32] !== 20'h20000 || gaddr_q[64] !== 20'h20000) begin
                failures++;
                $display("[TB] FAIL frame_wrap got %h %h %h required 1001f 20000 20000",
                         gaddr_q[31], gaddr_q[32], gaddr_q[64]);
            end
        end
        checks++;
        if (fd_pulses != 2) begin
            failures++;
            $display("[TB] FAIL frame_pulses got %0d required 2", fd_pulses);
        end
    endtask

    task automatic test_drain();
        int fall;
        do_reset();
        lat = 10;
        start_fetch(20'h10000);
        for (int i = 0; i < 20 && grants < 2; i++) tick();
        enable = 1'b0;
        tick();
        no_req = 1'b1;
        fall = -1;
        for (int i = 0; i < 40 && fall < 0; i++) begin
            tick();
            if (busy === 1'b0) fall = cyc;
        end
        no_req = 1'b0;
        checks++;
        if (grants != 3 || writes != 3) begin
            failures++;
            $display("[TB] FAIL drain_counts got grants=%0d writes=%0d required 3 3", grants, writes);
        end
        checks++;
        if (fall < 0 || !busy_at_last_wr || fall <= last_wr_cyc || fall - last_wr_cyc > 3) begin
            failures++;
            $display("[TB] FAIL drain_busy got fall=%0d last_wr=%0d busy_at_wr=%b required fall 1..3 after",
                     fall, last_wr_cyc, busy_at_last_wr);
        end
        lat = 2;
        wr_cnt = 0;
        start_fetch(20'h30000);
        for (int i = 0; i < 20 && grants < 4; i++) tick();
        checks++;
        if (gaddr_q.size() < 4 || gaddr_q[3] !== 20'h30000) begin
            failures++;
            $display("[TB] FAIL reenable_addr got %0d grants required 4th at 30000", gaddr_q.size());
        end
    endtask

    task automatic test_error();
        do_reset();
        repeat (2) tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clear got %b required 0", err);
        end
        inject = 1'b1;
        repeat (4) tick();
        checks++;
        if (err !== 1'b1 || writes != 0) begin
            failures++;
            $display("[TB] FAIL err_set got err=%b writes=%0d required 1 0", err, writes);
        end
        repeat (5) tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_sticky got %b required 1", err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_reset got %b required 0", err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        fb_base = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        fifo_level = '0;
        test_reset();
        test_back_to_back();
        test_credit();
        test_gnt_stall();
        test_frame();
        test_drain();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
